// File: rtl/snn_pkg.sv
// Shared types and constants for the spike encoder.
package snn_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    GEN  = 2'd2
  } enc_state_t;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LANE_SEED_STEP = 16'h1111;

  // Per-lane seed: base ^ (lane * step), truncated to 16 bits; zero is illegal for an LFSR.
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int lane);
    logic [15:0] s;
    s = base ^ (LANE_SEED_STEP * lane[15:0]);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One Galois LFSR lane; advances only when en_i is high.
module lfsr_lane
  import snn_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] rnd_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  logic [WIDTH-1:0] state;

  // Shift right, folding the taps in when the outgoing bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= SEED;
    end else if (en_i) begin
      state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
    end
  end

  assign rnd_o = state;

endmodule

// File: rtl/spike_encoder.sv
// Rate-codes a stored image into one Bernoulli spike vector per time step.
//
// Pixel stream handshake: a beat transfers on a rising edge where pix_valid_i
// and pix_ready_o are both high. pix_ready_o is high only in LOAD; the source
// must hold data/last stable while valid is high and ready is low.
//
// Step handshake: step_i is a one-cycle request honoured only in WAIT. In
// LOAD or GEN it is dropped and overrun_o is set (sticky until reset).
// The finished vector appears on spike_o at the same edge that raises the
// one-cycle spike_valid_o pulse.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int          numPixel   = 961,
  parameter int          PIX_WIDTH  = 8,
  parameter int          LANES      = 31,
  parameter int          NUM_STEPS  = 100,
  parameter int          LFSR_WIDTH = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  input  logic [PIX_WIDTH-1:0] pix_data_i,
  input  logic                 pix_last_i,
  input  logic                 step_i,
  output logic [numPixel-1:0]  spike_o,
  output logic                 spike_valid_o,
  output logic                 img_done_o,
  output logic                 overrun_o,
  output logic [1:0]           state_o
);

  localparam int ROWS   = (numPixel + LANES - 1) / LANES;
  localparam int PAD    = ROWS * LANES;
  localparam int PAD_W  = (PAD > 1) ? $clog2(PAD) : 1;
  localparam int CNT_W  = (numPixel > 1) ? $clog2(numPixel + 1) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  enc_state_t state, state_nxt;

  logic [CNT_W-1:0]     pix_cnt;
  logic [ROW_W-1:0]     row;
  logic [STEP_W-1:0]    step_cnt;
  logic [PIX_WIDTH-1:0] pix_buf [numPixel];
  logic [PIX_WIDTH-1:0] pix_pad [PAD];
  logic [LFSR_WIDTH-1:0] lane_rnd [LANES];
  logic [LANES-1:0]     rnd_hi_unused;
  logic [LANES-1:0]     row_bits;
  logic [PAD_W-1:0]     row_base;
  logic [PAD-1:0]       shadow, shadow_nxt;

  logic pix_we;
  logic lfsr_en;
  logic vec_done;
  logic img_end;
  logic step_go;

  // Pad the buffer to a whole number of rows; padding pixels read as zero.
  for (genvar p = 0; p < PAD; p++) begin : g_pad
    if (p < numPixel) begin : g_real
      assign pix_pad[p] = pix_buf[p];
    end else begin : g_zero
      assign pix_pad[p] = '0;
    end
  end

  assign row_base = PAD_W'(row) * PAD_W'(LANES);

  // One LFSR and one comparator per lane; lane c encodes pixel row*LANES+c.
  for (genvar c = 0; c < LANES; c++) begin : g_lane
    lfsr_lane #(
      .WIDTH (LFSR_WIDTH),
      .SEED  (LFSR_WIDTH'(lane_seed(SEED, c)))
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (lfsr_en),
      .rnd_o  (lane_rnd[c])
    );
    assign row_bits[c]      = pix_pad[row_base + PAD_W'(c)] > lane_rnd[c][PIX_WIDTH-1:0];
    assign rnd_hi_unused[c] = ^lane_rnd[c][LFSR_WIDTH-1:PIX_WIDTH];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= LOAD;
    else         state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    pix_ready_o = 1'b0;
    pix_we      = 1'b0;
    lfsr_en     = 1'b0;
    vec_done    = 1'b0;
    img_end     = 1'b0;
    step_go     = 1'b0;
    case (state)
      LOAD: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          pix_we = 1'b1;
          if (pix_last_i || (pix_cnt == CNT_W'(numPixel - 1))) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (step_i) begin
          step_go   = 1'b1;
          state_nxt = GEN;
        end
      end
      GEN: begin
        lfsr_en = 1'b1;
        if (row == ROW_W'(ROWS - 1)) begin
          vec_done = 1'b1;
          if (step_cnt == STEP_W'(NUM_STEPS - 1)) begin
            img_end   = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Pixel buffer; cleared when an image finishes so a short next image reads zeros beyond its end.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || img_end) begin
      for (int p = 0; p < numPixel; p++) pix_buf[p] <= '0;
    end else if (pix_we) begin
      pix_buf[pix_cnt] <= pix_data_i;
    end
  end

  // Merge the current row's spike bits into the vector being built.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[row_base +: LANES] = row_bits;
  end

  // Shadow vector under construction; never visible until the last row completes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)          shadow <= '0;
    else if (state == GEN) shadow <= shadow_nxt;
  end

  // Counters, published vector, and status pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pix_cnt       <= '0;
      row           <= '0;
      step_cnt      <= '0;
      spike_o       <= '0;
      spike_valid_o <= 1'b0;
      img_done_o    <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      spike_valid_o <= vec_done;
      img_done_o    <= img_end;
      if (step_i && (state != WAIT)) overrun_o <= 1'b1;
      if (img_end)     pix_cnt <= '0;
      else if (pix_we) pix_cnt <= pix_cnt + 1'b1;
      if (step_go)               row <= '0;
      else if (state == GEN)     row <= vec_done ? '0 : row + 1'b1;
      if (vec_done) begin
        spike_o  <= shadow_nxt[numPixel-1:0];
        step_cnt <= img_end ? '0 : step_cnt + 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule
